instr_memory: RTL and testbench



---
 rtl/instr_memory_pkg.sv | 11 +
 rtl/instr_memory_ram.sv | 43 ++++
 rtl/instr_memory.sv | 65 ++++++
 tb/tb_instr_memory.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/instr_memory_pkg.sv
// Shared constants for the instruction memory: the NOP encoding that the
// fetch register resets to and the default word depth.
package instr_memory_pkg;

  // addi x0, x0, 0 -- the canonical RISC-V NOP.
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Default number of 32-bit words held by the memory.
  localparam int DEFAULT_DEPTH = 1024;

endpackage

// File: rtl/instr_memory_ram.sv
// imem_ram: word array with one write port, one registered read port for
// instruction fetch and one combinational read port for debug inspection.
// The array is named mem so the contents can be preloaded or inspected
// hierarchically.
module imem_ram
  import instr_memory_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read_en,
  input  logic [ADDR_W-1:0] read_idx,
  output logic [31:0]       read_data,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_idx,
  input  logic [31:0]       write_data,
  input  logic [ADDR_W-1:0] debug_idx,
  output logic [31:0]       debug_data
);

  logic [31:0] mem [0:DEPTH-1];

  // Word write; the array itself is never reset so a loaded program survives.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[write_idx] <= write_data;
    end
  end

  // Registered fetch read; sampling the old word makes same-edge writes read-before-write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data <= NOP;
    end else if (read_en) begin
      read_data <= mem[read_idx];
    end
  end

  assign debug_data = mem[debug_idx];

endmodule

// File: rtl/instr_memory.sv
// instr_memory: instruction memory for the fetch stage. Slices byte addresses
// down to word indices (low two bits and bits above the array ignored, so
// addresses wrap) and gates the debug port.
// Optional feature macro: IMEM_DEBUG_PORT_EN enables debug writes and debug
// reads; without it the debug inputs are ignored and debug_data_out is zero.
module instr_memory
  import instr_memory_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        read_en,
  output logic [31:0] data_out,
  input  logic        debug_en,
  input  logic [31:0] debug_addr,
  input  logic [31:0] debug_data_in,
  input  logic        debug_write_en,
  output logic [31:0] debug_data_out
);

  logic [ADDR_W-1:0] fetch_idx;
  logic [ADDR_W-1:0] debug_idx;
  logic              write_en;
  logic [31:0]       ram_debug_data;
  logic              unused_addr_bits;

  assign fetch_idx = addr[ADDR_W+1:2];
  assign debug_idx = debug_addr[ADDR_W+1:2];

  // Byte-offset and wrap-around bits carry no meaning for a word array.
  assign unused_addr_bits = ^{addr[31:ADDR_W+2], addr[1:0],
                              debug_addr[31:ADDR_W+2], debug_addr[1:0]};

`ifdef IMEM_DEBUG_PORT_EN
  // No write may land while reset is held, even if the debug strobe is high.
  assign write_en       = debug_en && debug_write_en && !reset;
  assign debug_data_out = debug_en ? ram_debug_data : 32'h0;
`else
  logic unused_debug;

  assign write_en       = 1'b0;
  assign debug_data_out = 32'h0;
  assign unused_debug   = ^{debug_en, debug_write_en, ram_debug_data};
`endif

  imem_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk        (clk),
    .reset      (reset),
    .read_en    (read_en),
    .read_idx   (fetch_idx),
    .read_data  (data_out),
    .write_en   (write_en),
    .write_idx  (debug_idx),
    .write_data (debug_data_in),
    .debug_idx  (debug_idx),
    .debug_data (ram_debug_data)
  );

endmodule

// File: tb/tb_instr_memory.sv
// Directed testbench for instr_memory. Expected values are hand-computed;
// the debug-port expectations follow IMEM_DEBUG_PORT_EN.
module tb_instr_memory;
  import instr_memory_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        read_en;
  logic [31:0] data_out;
  logic        debug_en;
  logic [31:0] debug_addr;
  logic [31:0] debug_data_in;
  logic        debug_write_en;
  logic [31:0] debug_data_out;

  int check_count = 0;
  int pass_count  = 0;

  localparam logic [31:0] WORD6 = 32'h0050_0093;

`ifdef IMEM_DEBUG_PORT_EN
  localparam bit DBG = 1'b1;
`else
  localparam bit DBG = 1'b0;
`endif

  instr_memory dut (
    .clk            (clk),
    .reset          (reset),
    .addr           (addr),
    .read_en        (read_en),
    .data_out       (data_out),
    .debug_en       (debug_en),
    .debug_addr     (debug_addr),
    .debug_data_in  (debug_data_in),
    .debug_write_en (debug_write_en),
    .debug_data_out (debug_data_out)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got === exp) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic ren, input logic [31:0] a,
                               input logic den, input logic dwe,
                               input logic [31:0] da, input logic [31:0] dd);
    read_en        = ren;
    addr           = a;
    debug_en       = den;
    debug_write_en = dwe;
    debug_addr     = da;
    debug_data_in  = dd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 1024; i++) begin
      dut.u_ram.mem[i] = NOP;
    end
    dut.u_ram.mem[6] = WORD6;
    #1;
    checkOutput("reset_nop", data_out, NOP);
    tick();
    reset = 1'b0;

    // Basic fetch after reset, plus a preloaded non-NOP word.
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("fetch_0", data_out, NOP);
    applyStimulus(1'b1, 32'h18, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("fetch_18", data_out, WORD6);

    // Debug write to 0x8, then fetch it back.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 32'hCAFE_BABE);
    tick();
    checkOutput("dbg_read_after_wr", debug_data_out, DBG ? 32'hCAFE_BABE : 32'h0);
    checkOutput("hold_no_read_en", data_out, WORD6);
    applyStimulus(1'b1, 32'h8, 1'b1, 1'b0, 32'h8, 32'h0);
    tick();
    checkOutput("fetch_8", data_out, DBG ? 32'hCAFE_BABE : NOP);
    checkOutput("dbg_read_8", debug_data_out, DBG ? 32'hCAFE_BABE : 32'h0);

    // Write with debug_en low must be ignored.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'hC, 32'hDEAD_BEEF);
    #1;
    checkOutput("dbg_read_disabled", debug_data_out, 32'h0);
    tick();
    applyStimulus(1'b1, 32'hC, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("fetch_C_ignored_wr", data_out, NOP);

    // Same-edge fetch and write to 0x10: old word first, new word next edge.
    applyStimulus(1'b1, 32'h10, 1'b1, 1'b1, 32'h10, 32'h1234_5678);
    tick();
    checkOutput("rbw_old", data_out, NOP);
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("rbw_new", data_out, DBG ? 32'h1234_5678 : NOP);

    // Wrap-around and ignored low address bits.
    applyStimulus(1'b1, 32'h1008, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("wrap_1008", data_out, DBG ? 32'hCAFE_BABE : NOP);
    applyStimulus(1'b1, 32'h000A, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("lowbits_000A", data_out, DBG ? 32'hCAFE_BABE : NOP);
    applyStimulus(1'b1, 32'h1018, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("wrap_1018", data_out, WORD6);
    applyStimulus(1'b1, 32'h001B, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("lowbits_001B", data_out, WORD6);

    // read_en low holds the previous word.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("hold_value", data_out, WORD6);

    // Asynchronous reset between edges; memory contents must survive.
    applyStimulus(1'b1, 32'h8, 1'b1, 1'b0, 32'h8, 32'h0);
    tick();
    checkOutput("pre_reset_fetch", data_out, DBG ? 32'hCAFE_BABE : NOP);
    applyStimulus(1'b1, 32'h18, 1'b1, 1'b0, 32'h8, 32'h0);
    tick();
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_nop", data_out, NOP);
    checkOutput("mem_survives_reset", debug_data_out, DBG ? 32'hCAFE_BABE : 32'h0);

    // A debug write while reset is held must not land.
    applyStimulus(1'b1, 32'h18, 1'b1, 1'b1, 32'h14, 32'h1111_1111);
    tick();
    checkOutput("reset_holds_nop", data_out, NOP);
    reset = 1'b0;
    applyStimulus(1'b1, 32'h18, 1'b1, 1'b0, 32'h14, 32'h0);
    #1;
    checkOutput("wr_suppressed_in_reset", debug_data_out, DBG ? NOP : 32'h0);
    tick();
    checkOutput("fetch_after_release", data_out, WORD6);

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #20000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
